jesd_adc_link_sync: RTL and testbench

//  Link-control successor to the ADC pin PHY: takes the buffered single-ended SYSREF and per-lane receiver status, and generates the local LMFC.

---
 rtl/jesd_adc_pkg.sv | 17 +
 rtl/jesd_sysref_edge.sv | 30 +++
 rtl/jesd_adc_link_sync.sv | 190 +++++++++++++++++++
 tb/tb_jesd_adc_link_sync.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd_adc_pkg.sv
// Shared types and sizing helpers for the JESD204B ADC link-control block.
package jesd_adc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CGS  = 2'd1,
        ILAS = 2'd2,
        DATA = 2'd3
    } link_state_t;

    localparam int SYSREF_CNT_W = 8;

    function automatic int LMFC_CNT_W(input int period);
        return (period > 2) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/jesd_sysref_edge.sv
// SYSREF synchroniser into the device-clock domain followed by a registered rising-edge detector.
// The edge pulse lags the sysref input by SYNC_STAGES+1 clock cycles.
module jesd_sysref_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sysref,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sysref};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/jesd_adc_link_sync.sv
// JESD204B receive link control: SYSREF-aligned LMFC generation and SYNC~ sequencing through IDLE/CGS/ILAS/DATA.
// Optional macro SYSREF_REALIGN_EN: every SYSREF edge reloads the LMFC phase (continuous mode); otherwise only the first does.
module jesd_adc_link_sync
    import jesd_adc_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int LMFC_PERIOD  = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int CGS_TIMEOUT  = 4096,
    parameter int ILAS_MFRAMES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    sysref_i,
    input  logic                    link_en_i,
    input  logic [NUM_LANES-1:0]    lane_cgs_ok_i,
    input  logic [NUM_LANES-1:0]    lane_err_i,
    output logic                    lmfc_o,
    output logic                    sync_n_o,
    output logic                    link_up_o,
    output logic [1:0]              state_o,
    output logic [SYSREF_CNT_W-1:0] sysref_cnt_o,
    output logic                    misalign_o,
    output logic                    error_o
);

    localparam int LW = LMFC_CNT_W(LMFC_PERIOD);
    localparam int TW = $clog2(CGS_TIMEOUT) + 1;
    localparam int IW = $clog2(ILAS_MFRAMES) + 1;

    localparam logic [LW-1:0] LMFC_LAST = LW'(LMFC_PERIOD - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(CGS_TIMEOUT - 1);
    localparam logic [IW-1:0] ILAS_LAST = IW'(ILAS_MFRAMES - 1);

    logic                    w_edge;
    logic                    w_all_ok;
    logic                    w_any_err;
    logic                    w_drop;
    logic                    w_realign;
    logic [LW-1:0]           w_lmfc_cnt_nat;
    logic [LW-1:0]           w_lmfc_cnt_next;
    logic                    w_lmfc_next;
    logic                    w_tmo_hit;
    logic                    w_set_err;
    link_state_t             w_state_next;

    logic [LW-1:0]           r_lmfc_cnt;
    logic                    r_lmfc;
    logic                    r_aligned;
    logic [SYSREF_CNT_W-1:0] r_sysref_cnt;
    logic                    r_misalign;
    logic                    r_error;
    link_state_t             r_state;
    logic [TW-1:0]           r_tmo_cnt;
    logic [IW-1:0]           r_ilas_cnt;

    jesd_sysref_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sysref_edge (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_sysref(sysref_i),
        .o_edge  (w_edge)
    );

    assign w_all_ok  = &lane_cgs_ok_i;
    assign w_any_err = |lane_err_i;
    assign w_drop    = !link_en_i && (r_state != IDLE);
    assign w_tmo_hit = (r_state == CGS) && (r_tmo_cnt == TMO_LAST);

    // The phase check uses the value the counter would take without SYSREF, so an edge landing on the wrap is in phase.
    always_comb begin
`ifdef SYSREF_REALIGN_EN
        w_realign = w_edge;
`else
        w_realign = w_edge && !r_aligned;
`endif
        w_lmfc_cnt_nat  = (r_lmfc_cnt == LMFC_LAST) ? '0 : r_lmfc_cnt + LW'(1);
        w_lmfc_cnt_next = r_lmfc_cnt;
        if (w_drop) begin
            w_lmfc_cnt_next = '0;
        end else if (w_realign) begin
            w_lmfc_cnt_next = '0;
        end else if (r_aligned) begin
            w_lmfc_cnt_next = w_lmfc_cnt_nat;
        end
        w_lmfc_next = !w_drop && (w_realign || r_aligned) && (w_lmfc_cnt_next == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lmfc_cnt   <= '0;
            r_lmfc       <= 1'b0;
            r_aligned    <= 1'b0;
            r_sysref_cnt <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_lmfc_cnt <= w_lmfc_cnt_next;
            r_lmfc     <= w_lmfc_next;
            if (w_drop) begin
                r_aligned <= 1'b0;
            end else if (w_edge) begin
                r_aligned <= 1'b1;
            end
            if (w_edge && (r_sysref_cnt != '1)) begin
                r_sysref_cnt <= r_sysref_cnt + SYSREF_CNT_W'(1);
            end
            if (w_drop) begin
                r_misalign <= 1'b0;
            end else if (w_edge && r_aligned && (w_lmfc_cnt_nat != '0)) begin
                r_misalign <= 1'b1;
            end
        end
    end

    // ILAS and DATA entries are taken on the cycle whose registered lmfc_o is about to rise.
    always_comb begin
        w_state_next = r_state;
        w_set_err    = 1'b0;
        if (!link_en_i) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_aligned) begin
                        w_state_next = CGS;
                    end
                end
                CGS: begin
                    if (w_all_ok && w_lmfc_next) begin
                        w_state_next = ILAS;
                    end else if (w_tmo_hit) begin
                        w_set_err = 1'b1;
                    end
                end
                ILAS: begin
                    if (!w_all_ok) begin
                        w_state_next = CGS;
                    end else if (w_lmfc_next && (r_ilas_cnt == ILAS_LAST)) begin
                        w_state_next = DATA;
                    end
                end
                DATA: begin
                    if (!w_all_ok || w_any_err) begin
                        w_state_next = CGS;
                        w_set_err    = 1'b1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_tmo_cnt  <= '0;
            r_ilas_cnt <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state != CGS) || w_tmo_hit) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
            if (r_state != ILAS) begin
                r_ilas_cnt <= '0;
            end else if (w_lmfc_next) begin
                r_ilas_cnt <= r_ilas_cnt + IW'(1);
            end
            if (w_drop) begin
                r_error <= 1'b0;
            end else if (w_set_err) begin
                r_error <= 1'b1;
            end
        end
    end

    assign lmfc_o       = r_lmfc;
    assign sync_n_o     = (r_state == ILAS) || (r_state == DATA);
    assign link_up_o    = (r_state == DATA);
    assign state_o      = r_state;
    assign sysref_cnt_o = r_sysref_cnt;
    assign misalign_o   = r_misalign;
    assign error_o      = r_error;

endmodule

// File: tb/tb_jesd_adc_link_sync.sv
// Directed self-checking bench for jesd_adc_link_sync: LMFC alignment, SYNC~ sequencing, timeout, errors and async reset.
// Expectations for the second SYSREF follow the SYSREF_REALIGN_EN macro.
module tb_jesd_adc_link_sync;

    localparam int NUM_LANES    = 4;
    localparam int LMFC_PERIOD  = 16;
    localparam int SYNC_STAGES  = 2;
    localparam int CGS_TIMEOUT  = 4096;
    localparam int ILAS_MFRAMES = 4;

    logic                 clk = 1'b0;
    logic                 rstN = 1'b0;
    logic                 sysref = 1'b0;
    logic                 linkEn = 1'b0;
    logic [NUM_LANES-1:0] laneCgsOk = '0;
    logic [NUM_LANES-1:0] laneErr = '0;
    logic                 lmfc;
    logic                 syncN;
    logic                 linkUp;
    logic [1:0]           state;
    logic [7:0]           sysrefCnt;
    logic                 misalign;
    logic                 errorFlag;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string                name;
        int                   cycles;
        logic                 linkEn;
        logic [NUM_LANES-1:0] cgsOk;
        logic [NUM_LANES-1:0] laneErr;
        int                   expState;
        int                   expSyncN;
        int                   expLinkUp;
        int                   expError;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    jesd_adc_link_sync #(
        .NUM_LANES   (NUM_LANES),
        .LMFC_PERIOD (LMFC_PERIOD),
        .SYNC_STAGES (SYNC_STAGES),
        .CGS_TIMEOUT (CGS_TIMEOUT),
        .ILAS_MFRAMES(ILAS_MFRAMES)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rstN),
        .sysref_i     (sysref),
        .link_en_i    (linkEn),
        .lane_cgs_ok_i(laneCgsOk),
        .lane_err_i   (laneErr),
        .lmfc_o       (lmfc),
        .sync_n_o     (syncN),
        .link_up_o    (linkUp),
        .state_o      (state),
        .sysref_cnt_o (sysrefCnt),
        .misalign_o   (misalign),
        .error_o      (errorFlag)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        linkEn    = v.linkEn;
        laneCgsOk = v.cgsOk;
        laneErr   = v.laneErr;
        repeat (v.cycles) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_lmfc"}, int'(lmfc), 0);
        checkOutput({tag, "_sync_n"}, int'(syncN), 0);
        checkOutput({tag, "_link_up"}, int'(linkUp), 0);
        checkOutput({tag, "_state"}, int'(state), 0);
        checkOutput({tag, "_sysref_cnt"}, int'(sysrefCnt), 0);
        checkOutput({tag, "_misalign"}, int'(misalign), 0);
        checkOutput({tag, "_error"}, int'(errorFlag), 0);
    endtask

    task automatic countLmfc(input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (lmfc) pulses++;
        end
    endtask

    task automatic waitLmfc(input int bound, output int found);
        found = 0;
        for (int k = 0; k < bound && found == 0; k++) begin
            @(negedge clk);
            if (lmfc) found = 1;
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int firstK;
        int secondK;
        int pulses;
        int found;
        int prevSync;
        int prevUp;

        vecs[0] = '{"cgs_none",      20, 1'b1, 4'b0000, 4'b0000, 1, 0, 0, 0};
        vecs[1] = '{"cgs_lane3_out", 20, 1'b1, 4'b0111, 4'b0000, 1, 0, 0, 0};
        vecs[2] = '{"cgs_lane2_out", 20, 1'b1, 4'b1011, 4'b0000, 1, 0, 0, 0};
        vecs[3] = '{"cgs_lane1_err", 20, 1'b1, 4'b1101, 4'b0101, 1, 0, 0, 0};
        vecs[4] = '{"cgs_lane0_err", 20, 1'b1, 4'b1110, 4'b1111, 1, 0, 0, 0};

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rstN = 1'b1;

        countLmfc(40, pulses);
        checkOutput("no_lmfc_before_sysref", pulses, 0);

        // First SYSREF, held high six cycles to show a level gives a single edge.
        sysref = 1'b1;
        firstK = 0;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (lmfc) begin
                pulses++;
                if (firstK == 0) firstK = k;
            end
            if (k == 6) sysref = 1'b0;
        end
        checkOutput("first_lmfc_latency", firstK, SYNC_STAGES + 2);
        checkOutput("lmfc_pulses_in_30", pulses, 2);
        checkOutput("sysref_cnt_after_first", int'(sysrefCnt), 1);
        checkOutput("misalign_after_first", int'(misalign), 0);

        // SYSREF edge landing on the LMFC wrap: in phase.
        waitLmfc(40, found);
        checkOutput("lmfc_ref_found_a", found, 1);
        firstK = 0;
        secondK = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (lmfc) begin
                if (firstK == 0) firstK = k;
                else if (secondK == 0) secondK = k;
            end
            if (k == 12) sysref = 1'b1;
            if (k == 15) sysref = 1'b0;
        end
        checkOutput("inphase_first_pulse", firstK, 16);
        checkOutput("inphase_second_pulse", secondK, 32);
        checkOutput("inphase_misalign", int'(misalign), 0);
        checkOutput("sysref_cnt_inphase", int'(sysrefCnt), 2);

        // SYSREF edge five cycles into the multiframe: off phase.
        waitLmfc(40, found);
        checkOutput("lmfc_ref_found_b", found, 1);
        firstK = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (lmfc && firstK == 0) firstK = k;
            if (k == 1) sysref = 1'b1;
            if (k == 3) sysref = 1'b0;
        end
`ifdef SYSREF_REALIGN_EN
        checkOutput("offphase_next_pulse", firstK, 5);
`else
        checkOutput("offphase_next_pulse", firstK, 16);
`endif
        checkOutput("offphase_misalign", int'(misalign), 1);
        checkOutput("sysref_cnt_offphase", int'(sysrefCnt), 3);

        // Link enable: CGS entry and lane-status table while waiting for lock.
        linkEn = 1'b1;
        @(negedge clk);
        checkOutput("idle_to_cgs_state", int'(state), 1);
        checkOutput("idle_to_cgs_sync_n", int'(syncN), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            checkOutput({vecs[i].name, "_state"}, int'(state), vecs[i].expState);
            checkOutput({vecs[i].name, "_sync_n"}, int'(syncN), vecs[i].expSyncN);
            checkOutput({vecs[i].name, "_link_up"}, int'(linkUp), vecs[i].expLinkUp);
            checkOutput({vecs[i].name, "_error"}, int'(errorFlag), vecs[i].expError);
        end

        // All lanes locked: SYNC~ rises with the next LMFC, DATA after ILAS_MFRAMES more.
        laneCgsOk = 4'hF;
        laneErr = 4'h0;
        prevSync = int'(syncN);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (lmfc) begin
                found = 1;
                checkOutput("sync_n_rises_on_lmfc", int'(syncN), 1);
                checkOutput("sync_n_low_before_lmfc", prevSync, 0);
                checkOutput("state_ilas", int'(state), 2);
            end
            prevSync = int'(syncN);
        end
        checkOutput("ilas_entry_found", found, 1);

        pulses = 0;
        prevUp = int'(linkUp);
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clk);
            if (lmfc) begin
                pulses++;
                if (pulses == ILAS_MFRAMES) begin
                    found = 1;
                    checkOutput("link_up_on_4th_lmfc", int'(linkUp), 1);
                    checkOutput("link_up_low_before", prevUp, 0);
                    checkOutput("state_data", int'(state), 3);
                end
            end
            prevUp = int'(linkUp);
        end
        checkOutput("data_entry_found", found, 1);

        // One-cycle lane error in DATA.
        laneErr = 4'b0010;
        @(negedge clk);
        laneErr = 4'b0000;
        checkOutput("lane_err_state", int'(state), 1);
        checkOutput("lane_err_sync_n", int'(syncN), 0);
        checkOutput("lane_err_error", int'(errorFlag), 1);
        checkOutput("lane_err_link_up", int'(linkUp), 0);

        linkEn = 1'b0;
        @(negedge clk);
        checkOutput("disable_state", int'(state), 0);
        checkOutput("disable_error", int'(errorFlag), 0);
        checkOutput("disable_misalign", int'(misalign), 0);
        countLmfc(40, pulses);
        checkOutput("no_lmfc_after_disable", pulses, 0);

        // CGS timeout with lane 3 never locking.
        sysref = 1'b1;
        repeat (3) @(negedge clk);
        sysref = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("sysref_cnt_fourth", int'(sysrefCnt), 4);
        linkEn = 1'b1;
        laneCgsOk = 4'b0111;
        for (int n = 1; n <= CGS_TIMEOUT + 1; n++) begin
            @(negedge clk);
            if (n == 1) checkOutput("tmo_state_cgs", int'(state), 1);
            if (n == CGS_TIMEOUT) checkOutput("tmo_error_not_yet", int'(errorFlag), 0);
            if (n == CGS_TIMEOUT + 1) begin
                checkOutput("tmo_error_set", int'(errorFlag), 1);
                checkOutput("tmo_state_stays_cgs", int'(state), 1);
                checkOutput("tmo_sync_n_low", int'(syncN), 0);
            end
        end

        // Asynchronous reset in the middle of ILAS.
        linkEn = 1'b0;
        @(negedge clk);
        checkOutput("disable2_error", int'(errorFlag), 0);
        sysref = 1'b1;
        repeat (3) @(negedge clk);
        sysref = 1'b0;
        repeat (5) @(negedge clk);
        linkEn = 1'b1;
        laneCgsOk = 4'hF;
        found = 0;
        for (int k = 0; k < 80 && found == 0; k++) begin
            @(negedge clk);
            if (state == 2'd2) found = 1;
        end
        checkOutput("reach_ilas_for_reset", found, 1);
        repeat (10) @(negedge clk);
        checkOutput("still_ilas_before_reset", int'(state), 2);
        #3;
        rstN = 1'b0;
        #1;
        checkResetValues("async_reset");
        @(negedge clk);
        linkEn = 1'b0;
        rstN = 1'b1;
        countLmfc(40, pulses);
        checkOutput("no_lmfc_after_reset", pulses, 0);
        checkOutput("idle_after_reset", int'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
